// File: rtl/pir_conditioner.sv
// PIR sensor conditioner: synchronises and debounces the raw PIR pin,
// locks out the sensor during power-up warm-up, then stretches detected
// motion by a hold time and counts motion onsets.
//
// Ports:
//   clk_148Mhz    - system clock
//   reset         - asynchronous, active-high reset
//   pir_raw       - asynchronous PIR sensor pin
//   clear_count   - synchronous clear of event_count (wins over increment)
//   motion_active - conditioned motion level (high in ACTIVE or HOLD)
//   motion_pulse  - one-cycle strobe per accepted motion onset
//   pir_clean     - synchronised and filtered sensor level
//   warmup_done   - high once the warm-up lockout has expired
//   event_count   - saturating 16-bit count of motion onsets
module pir_conditioner #(
    parameter int unsigned FILTER_CYCLES = 148000,
    parameter int unsigned WARMUP_CYCLES = 296000000,
    parameter int unsigned HOLD_CYCLES   = 444000000
) (
    input  logic        clk_148Mhz,
    input  logic        reset,
    input  logic        pir_raw,
    input  logic        clear_count,
    output logic        motion_active,
    output logic        motion_pulse,
    output logic        pir_clean,
    output logic        warmup_done,
    output logic [15:0] event_count
);

    localparam logic [28:0] FILT_LAST = 29'(FILTER_CYCLES - 1);
    localparam logic [28:0] WARM_LAST = 29'(WARMUP_CYCLES - 1);
    localparam logic [28:0] HOLD_LAST = 29'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WARMUP,
        IDLE,
        ACTIVE,
        HOLD
    } state_t;

    state_t      state;
    logic [1:0]  sync_q;
    logic        pir_sync;
    logic [28:0] filt_cnt;
    logic [28:0] warm_cnt;
    logic [28:0] hold_cnt;
    logic        onset;

    assign pir_sync = sync_q[1];

    // A motion onset is an entry into ACTIVE from IDLE or HOLD.
    always_comb begin
        onset = 1'b0;
        if (pir_clean && (state == IDLE || state == HOLD)) begin
            onset = 1'b1;
        end
    end

    always_ff @(posedge clk_148Mhz or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pir_raw};
        end
    end

    // pir_clean only follows the synchronised level after it has
    // disagreed for FILTER_CYCLES consecutive cycles.
    always_ff @(posedge clk_148Mhz or posedge reset) begin
        if (reset) begin
            filt_cnt  <= '0;
            pir_clean <= 1'b0;
        end else if (pir_sync != pir_clean) begin
            if (filt_cnt == FILT_LAST) begin
                pir_clean <= ~pir_clean;
                filt_cnt  <= '0;
            end else begin
                filt_cnt <= filt_cnt + 29'd1;
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    // motion_active is set on the same edge as the state it decodes, so it
    // tracks ACTIVE/HOLD exactly; warmup_done lags the IDLE entry by one.
    always_ff @(posedge clk_148Mhz or posedge reset) begin
        if (reset) begin
            state         <= WARMUP;
            warm_cnt      <= '0;
            hold_cnt      <= '0;
            motion_active <= 1'b0;
            motion_pulse  <= 1'b0;
            warmup_done   <= 1'b0;
            event_count   <= 16'h0000;
        end else begin
            motion_pulse <= onset;
            warmup_done  <= (state != WARMUP);

            if (clear_count) begin
                event_count <= 16'h0000;
            end else if (onset && event_count != 16'hFFFF) begin
                event_count <= event_count + 16'd1;
            end

            unique case (state)
                WARMUP: begin
                    if (warm_cnt == WARM_LAST) begin
                        state <= IDLE;
                    end else begin
                        warm_cnt <= warm_cnt + 29'd1;
                    end
                end
                IDLE: begin
                    if (pir_clean) begin
                        state         <= ACTIVE;
                        motion_active <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!pir_clean) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    // Retrigger outranks timer expiry.
                    if (pir_clean) begin
                        state <= ACTIVE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state         <= IDLE;
                        motion_active <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 29'd1;
                    end
                end
                default: begin
                    state         <= WARMUP;
                    motion_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pir_conditioner.sv
// Self-checking bench for pir_conditioner: directed scenarios with literal
// expectations plus randomized pin activity checked against a timeline model.
module tb_pir_conditioner;

    localparam int F = 4;
    localparam int W = 16;
    localparam int H = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pir_raw = 1'b1;
    logic        clear_count = 1'b0;
    logic        motion_active;
    logic        motion_pulse;
    logic        pir_clean;
    logic        warmup_done;
    logic [15:0] event_count;

    int checks = 0;
    int failures = 0;

    pir_conditioner #(
        .FILTER_CYCLES(F),
        .WARMUP_CYCLES(W),
        .HOLD_CYCLES(H)
    ) dut (
        .clk_148Mhz(clk),
        .reset(reset),
        .pir_raw(pir_raw),
        .clear_count(clear_count),
        .motion_active(motion_active),
        .motion_pulse(motion_pulse),
        .pir_clean(pir_clean),
        .warmup_done(warmup_done),
        .event_count(event_count)
    );

    always #5 clk = ~clk;

    // Timeline model: m_t counts clock edges since reset release.
    int          m_t = 0;
    logic        m_s1 = 1'b0;
    logic        m_s2 = 1'b0;
    logic        m_clean = 1'b0;
    int          m_run = 0;
    logic        m_prev_elig = 1'b0;
    logic        m_have = 1'b0;
    int          m_last = 0;
    logic        m_active = 1'b0;
    logic        m_pulse = 1'b0;
    logic        m_wdone = 1'b0;
    logic [15:0] m_cnt = 16'h0000;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)",
                     name, act, exp, m_t);
        end
    endtask

    task automatic model_reset();
        m_t = 0;
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        m_clean = 1'b0;
        m_run = 0;
        m_prev_elig = 1'b0;
        m_have = 1'b0;
        m_last = 0;
        m_active = 1'b0;
        m_pulse = 1'b0;
        m_wdone = 1'b0;
        m_cnt = 16'h0000;
    endtask

    // Motion is "seen" at edge t when warm-up is over and the filtered
    // level was high; output is active while the last sighting is within
    // H edges, and an onset is a sighting not preceded by one.
    task automatic model_step();
        logic elig;
        logic nclean;
        m_t++;
        nclean = m_clean;
        if (m_s2 != m_clean) begin
            m_run++;
            if (m_run == F) begin
                nclean = ~m_clean;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        elig = (m_t >= W + 1) && m_clean;
        if (elig) begin
            m_have = 1'b1;
            m_last = m_t;
        end
        m_active = m_have && (m_t - m_last <= H);
        m_pulse = elig && !m_prev_elig;
        m_prev_elig = elig;
        if (clear_count) m_cnt = 16'h0000;
        else if (m_pulse && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_wdone = (m_t >= W + 1);
        m_s2 = m_s1;
        m_s1 = pir_raw;
        m_clean = nclean;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("motion_active", motion_active, m_active);
            check("motion_pulse", motion_pulse, m_pulse);
            check("pir_clean", pir_clean, m_clean);
            check("warmup_done", warmup_done, m_wdone);
            check("event_count", event_count, m_cnt);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic wait_clean(input logic v, input int lim);
        int n = 0;
        while (pir_clean !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("wait_clean", pir_clean, v);
    endtask

    initial begin
        int na;
        int np;
        int seen;

        // Reset state, raw already high.
        repeat (3) @(negedge clk);
        check("rst_clean", pir_clean, 0);
        check("rst_active", motion_active, 0);
        check("rst_wdone", warmup_done, 0);
        check("rst_count", event_count, 0);

        // Raw held high from release: warm-up ends, onset at edge 17.
        reset = 1'b0;
        repeat (16) @(negedge clk);
        check("req031_wdone_16", warmup_done, 0);
        check("req031_active_16", motion_active, 0);
        @(negedge clk);
        check("req031_wdone_17", warmup_done, 1);
        check("req031_pulse_17", motion_pulse, 1);
        check("req031_active_17", motion_active, 1);
        check("req031_count_17", event_count, 1);
        @(negedge clk);
        check("req031_pulse_18", motion_pulse, 0);
        pir_raw = 1'b0;
        repeat (30) @(negedge clk);
        check("req031_release", motion_active, 0);

        // Short 3-cycle glitch must never reach pir_clean.
        pir_raw = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen += pir_clean + motion_active;
        end
        pir_raw = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen += pir_clean + motion_active;
        end
        check("req032_glitch", seen, 0);
        check("req032_count", event_count, 1);

        // 20 high cycles: active for 20 + H cycles, one pulse.
        pir_raw = 1'b1;
        na = 0;
        np = 0;
        repeat (20) begin
            @(negedge clk);
            na += motion_active;
            np += motion_pulse;
        end
        pir_raw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            na += motion_active;
            np += motion_pulse;
        end
        check("req033_active_len", na, 20 + H);
        check("req033_pulses", np, 1);

        // Retrigger early in HOLD, then a full hold after final fall.
        pir_raw = 1'b1;
        repeat (10) @(negedge clk);
        pir_raw = 1'b0;
        wait_clean(1'b0, 20);
        pir_raw = 1'b1;
        np = 0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            np += motion_pulse;
            seen += !motion_active;
        end
        check("req034_pulse", np, 1);
        check("req034_no_drop", seen, 0);
        check("req034_count", event_count, 4);
        pir_raw = 1'b0;
        wait_clean(1'b0, 20);
        na = 0;
        repeat (20) begin
            @(negedge clk);
            na += motion_active;
        end
        check("req034_hold_len", na, H);

        // Saturation via preload, then clear coinciding with onset.
        @(negedge clk);
        force dut.event_count = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.event_count;
        check("req035_preload", event_count, 16'hFFFF);
        pir_raw = 1'b1;
        repeat (7) @(negedge clk);
        check("req035_sat_pulse", motion_pulse, 1);
        check("req035_sat_count", event_count, 16'hFFFF);
        pir_raw = 1'b0;
        repeat (30) @(negedge clk);
        pir_raw = 1'b1;
        repeat (6) @(negedge clk);
        clear_count = 1'b1;
        @(negedge clk);
        clear_count = 1'b0;
        check("req035_clr_pulse", motion_pulse, 1);
        check("req035_clr_count", event_count, 0);
        pir_raw = 1'b0;
        repeat (30) @(negedge clk);

        // Reset in HOLD: immediate drop and full warm-up again.
        pir_raw = 1'b1;
        repeat (10) @(negedge clk);
        pir_raw = 1'b0;
        wait_clean(1'b0, 20);
        repeat (3) @(negedge clk);
        check("req036_in_hold", motion_active, 1);
        #2;
        reset = 1'b1;
        #1;
        check("req036_active", motion_active, 0);
        check("req036_wdone", warmup_done, 0);
        check("req036_count", event_count, 0);
        @(negedge clk);
        reset = 1'b0;
        pir_raw = 1'b1;
        np = 0;
        repeat (16) begin
            @(negedge clk);
            np += motion_pulse;
        end
        check("req036_no_early", np, 0);
        @(negedge clk);
        check("req036_pulse", motion_pulse, 1);
        check("req036_wdone_17", warmup_done, 1);

        // Random pin activity with occasional clears and one reset.
        for (int i = 0; i < 150; i++) begin
            int len;
            pir_raw = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 20);
            if (i == 75) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            repeat (len) begin
                @(negedge clk);
                clear_count = ($urandom_range(0, 39) == 0);
            end
        end
        clear_count = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
